// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns a debounced, active-low button level into one-cycle press, release,
// long-press and auto-repeat events, plus a held-level flag. All outputs are
// registered. The long and repeat thresholds are run-time inputs.

module button_event_decoder (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_switch,
  input  logic [31:0] i_long_limit,
  input  logic [31:0] i_repeat_limit,
  output logic        o_press,
  output logic        o_release,
  output logic        o_long,
  output logic        o_repeat,
  output logic        o_held
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_LONG  = 2'd2;

  logic        prev_q, prev_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;
  logic        held_q, held_d;

  logic        press_edge;
  logic        release_edge;

  // Edge detection against the previous sample; the button idles high.
  always_comb begin
    press_edge   = prev_q & ~i_switch;
    release_edge = ~prev_q & i_switch;
  end

  // Next-state, counter and event decode. Release wins over long/repeat, and
  // the >= compares let a lowered limit fire on the very next cycle.
  always_comb begin
    prev_d    = i_switch;
    state_d   = state_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (press_edge) begin
          press_d = 1'b1;
          state_d = ST_PRESS;
        end
      end

      ST_PRESS: begin
        if (release_edge) begin
          release_d = 1'b1;
          count_d   = '0;
          state_d   = ST_IDLE;
        end else if ((i_long_limit != 32'd0) && (count_q >= i_long_limit)) begin
          long_d  = 1'b1;
          count_d = '0;
          state_d = ST_LONG;
        end else if (i_long_limit == 32'd0) begin
          count_d = '0;
        end else begin
          count_d = count_q + 32'd1;
        end
      end

      ST_LONG: begin
        if (release_edge) begin
          release_d = 1'b1;
          count_d   = '0;
          state_d   = ST_IDLE;
        end else if ((i_repeat_limit != 32'd0) && (count_q >= i_repeat_limit)) begin
          repeat_d = 1'b1;
          count_d  = '0;
        end else if (i_repeat_limit != 32'd0) begin
          count_d = count_q + 32'd1;
        end
      end

      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    held_d = (state_d != ST_IDLE);
  end

  // State, counter and registered outputs; the previous sample resets high.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      prev_q    <= 1'b1;
      state_q   <= ST_IDLE;
      count_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      state_q   <= state_d;
      count_q   <= count_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_held    = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder
// Drives directed and random button activity, predicts the output vector for
// every clock edge with a timestamp-based reference model, and has a separate
// monitor pop and compare those predictions against the DUT.

module tb_button_event_decoder;

  logic        i_clk;
  logic        i_reset;
  logic        i_switch;
  logic [31:0] i_long_limit;
  logic [31:0] i_repeat_limit;
  logic        o_press;
  logic        o_release;
  logic        o_long;
  logic        o_repeat;
  logic        o_held;

  int n_checks;
  int n_fail;

  // expected {press, release, long, repeat, held} for each upcoming edge
  logic [4:0] exp_q[$];

  // reference model: a press is open from its press edge until its release;
  // events fire when elapsed cycles since the last anchor reach the limit
  bit     m_prev;
  bit     m_pressed;
  bit     m_got_long;
  longint m_n;
  longint m_anchor;

  // monitor statistics taken from the DUT outputs
  int mon_cycle;
  int press_count;
  int release_count;
  int long_count;
  int repeat_count;
  int held_count;
  int last_press_cyc;
  int last_long_cyc;

  button_event_decoder dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_switch      (i_switch),
    .i_long_limit  (i_long_limit),
    .i_repeat_limit(i_repeat_limit),
    .o_press       (o_press),
    .o_release     (o_release),
    .o_long        (o_long),
    .o_repeat      (o_repeat),
    .o_held        (o_held)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d {press,release,long,repeat,held}: got %b required %b",
               name, mon_cycle, actual, expected);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_prev     = 1'b1;
    m_pressed  = 1'b0;
    m_got_long = 1'b0;
    m_anchor   = 0;
  endtask

  // Called at an edge+2 slot: drives the switch, predicts the next edge's
  // outputs from the current limits, then advances to the next edge+2 slot.
  task automatic applyStimulus(input logic sw);
    logic [4:0] e;
    longint     elapsed;
    longint     lim_l;
    longint     lim_r;
    i_switch = sw;
    lim_l    = i_long_limit;
    lim_r    = i_repeat_limit;
    elapsed  = m_n - m_anchor - 1;
    e        = 5'b0;
    if (m_pressed && !m_prev && sw) begin
      e[3]       = 1'b1;
      m_pressed  = 1'b0;
      m_got_long = 1'b0;
    end else if (!m_pressed && m_prev && !sw) begin
      e[4]      = 1'b1;
      m_pressed = 1'b1;
      m_anchor  = m_n;
    end else if (m_pressed && !m_got_long && lim_l != 0 && elapsed >= lim_l) begin
      e[2]       = 1'b1;
      m_got_long = 1'b1;
      m_anchor   = m_n;
    end else if (m_pressed && m_got_long && lim_r != 0 && elapsed >= lim_r) begin
      e[1]     = 1'b1;
      m_anchor = m_n;
    end
    e[0]   = m_pressed;
    m_prev = sw;
    m_n++;
    exp_q.push_back(e);
    @(posedge i_clk);
    #2;
  endtask

  task automatic holdFor(input logic sw, input int cycles);
    for (int k = 0; k < cycles; k++) applyStimulus(sw);
  endtask

  // Monitor: one edge+1 sample per clock, compared against the oldest prediction.
  initial begin
    logic [4:0] e;
    logic [4:0] act;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {o_press, o_release, o_long, o_repeat, o_held};
        mon_cycle++;
        if (o_press) begin press_count++; last_press_cyc = mon_cycle; end
        if (o_release) release_count++;
        if (o_long) begin long_count++; last_long_cyc = mon_cycle; end
        if (o_repeat) repeat_count++;
        if (o_held) held_count++;
        checkOutput("scoreboard", act, e);
      end
    end
  end

  initial begin
    int base_rel, base_long, base_rep, base_held, base_press;
    n_checks = 0; n_fail = 0; mon_cycle = 0;
    press_count = 0; release_count = 0; long_count = 0; repeat_count = 0;
    held_count = 0; last_press_cyc = 0; last_long_cyc = 0;
    m_n = 0;
    modelReset();
    i_reset        = 1'b0;
    i_switch       = 1'b1;
    i_long_limit   = 32'd0;
    i_repeat_limit = 32'd0;

    #1;
    checkOutput("reset_values", {o_press, o_release, o_long, o_repeat, o_held}, 5'b0);
    repeat (2) @(posedge i_clk);
    #2;
    i_reset = 1'b1;
    holdFor(1'b1, 3);

    // 1: short press with long-press disabled
    $display("[TB] short press, L=0");
    base_rel = release_count; base_long = long_count; base_held = held_count;
    holdFor(1'b0, 5);
    holdFor(1'b1, 4);
    checkValue("short_release_count", release_count - base_rel, 1);
    checkValue("short_long_count", long_count - base_long, 0);
    checkValue("short_held_cycles", held_count - base_held, 5);

    // 2: long press without repeat
    $display("[TB] long press, L=10 R=0");
    i_long_limit = 32'd10; i_repeat_limit = 32'd0;
    base_rel = release_count; base_long = long_count; base_rep = repeat_count;
    holdFor(1'b0, 30);
    holdFor(1'b1, 4);
    checkValue("long_count", long_count - base_long, 1);
    checkValue("long_latency", last_long_cyc - last_press_cyc, 11);
    checkValue("long_no_repeat", repeat_count - base_rep, 0);
    checkValue("long_release_count", release_count - base_rel, 1);

    // 3: long press with auto-repeat every 5 cycles
    $display("[TB] repeat, L=10 R=4");
    i_repeat_limit = 32'd4;
    base_rep = repeat_count; base_long = long_count;
    holdFor(1'b0, 40);
    holdFor(1'b1, 10);
    checkValue("repeat_count", repeat_count - base_rep, 5);
    checkValue("repeat_long_count", long_count - base_long, 1);

    // 4: release lands on the edge where the long event would fire
    $display("[TB] release collides with long");
    i_repeat_limit = 32'd0;
    base_rel = release_count; base_long = long_count;
    holdFor(1'b0, 11);
    holdFor(1'b1, 4);
    checkValue("collide_long_count", long_count - base_long, 0);
    checkValue("collide_release_count", release_count - base_rel, 1);

    // 5: reset while in the long state, button still held at reset exit
    $display("[TB] reset during long press");
    holdFor(1'b0, 20);
    base_rel = release_count; base_press = press_count;
    i_reset = 1'b0;
    #1;
    checkOutput("reset_async", {o_press, o_release, o_long, o_repeat, o_held}, 5'b0);
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_held", {o_press, o_release, o_long, o_repeat, o_held}, 5'b0);
    #1;
    i_reset = 1'b1;
    modelReset();
    holdFor(1'b0, 3);
    checkValue("reset_exit_press", press_count - base_press, 1);
    checkValue("reset_no_release", release_count - base_rel, 0);
    holdFor(1'b1, 4);

    // 6: lowering the long limit mid-press fires on the next edge
    $display("[TB] limit lowered mid-press");
    i_long_limit = 32'd1000;
    base_long = long_count;
    holdFor(1'b0, 501);
    checkValue("lower_no_early_long", long_count - base_long, 0);
    i_long_limit = 32'd100;
    holdFor(1'b0, 3);
    checkValue("lower_long_count", long_count - base_long, 1);
    checkValue("lower_still_held", int'(o_held), 1);
    holdFor(1'b1, 4);

    // 7: random presses with limits retuned between presses
    $display("[TB] random presses");
    for (int p = 0; p < 25; p++) begin
      i_long_limit   = $urandom_range(0, 12);
      i_repeat_limit = $urandom_range(0, 6);
      holdFor(1'b1, $urandom_range(1, 6));
      holdFor(1'b0, $urandom_range(1, 60));
    end
    holdFor(1'b1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
